// File: rtl/nw_pkg.sv
// Constants shared by the sequence loaders, the RAM_A/RAM_B readers and the NW core.
// This package must stay in sync with every reader of the sequence RAMs.
package nw_pkg;

    localparam logic [2:0] NT_G = 3'b001;
    localparam logic [2:0] NT_C = 3'b110;
    localparam logic [2:0] NT_A = 3'b100;
    localparam logic [2:0] NT_T = 3'b011;

    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_UC = 8'h43;
    localparam logic [7:0] CH_UG = 8'h47;
    localparam logic [7:0] CH_UT = 8'h54;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_LC = 8'h63;
    localparam logic [7:0] CH_LG = 8'h67;
    localparam logic [7:0] CH_LT = 8'h74;
    localparam logic [7:0] CH_TERM = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } load_state_t;

endpackage

// File: rtl/nt_encoder.sv
// Combinational ASCII-to-nucleotide encoder for the sequence loader.
// The terminator wins over any letter so a TERM override can never alias a nucleotide.
module nt_encoder
    import nw_pkg::*;
#(
    parameter logic [2:0] G    = NT_G,
    parameter logic [2:0] C    = NT_C,
    parameter logic [2:0] A    = NT_A,
    parameter logic [2:0] T    = NT_T,
    parameter logic [7:0] TERM = CH_TERM
) (
    input  logic [7:0] char_in,
    output logic [2:0] code,
    output logic       is_nt,
    output logic       is_term
);

    always_comb begin
        code    = '0;
        is_nt   = 1'b0;
        is_term = 1'b0;
        if (char_in == TERM) begin
            is_term = 1'b1;
        end else begin
            case (char_in)
                CH_UA, CH_LA: begin code = A; is_nt = 1'b1; end
                CH_UC, CH_LC: begin code = C; is_nt = 1'b1; end
                CH_UG, CH_LG: begin code = G; is_nt = 1'b1; end
                CH_UT, CH_LT: begin code = T; is_nt = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_ram_loader.sv
// Streams ASCII nucleotides into a sequence RAM from address 0 over a valid/ready handshake,
// reporting the loaded length and a sticky done/err status.
module seq_ram_loader
    import nw_pkg::*;
#(
    parameter int         N    = 128,
    parameter int         Bit  = $clog2(N + 1),
    parameter logic [2:0] G    = NT_G,
    parameter logic [2:0] C    = NT_C,
    parameter logic [2:0] A    = NT_A,
    parameter logic [2:0] T    = NT_T,
    parameter logic [7:0] TERM = CH_TERM
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   char_in,
    input  logic         char_valid,
    output logic         char_ready,
    output logic         en_din,
    output logic         we,
    output logic [Bit:0] addr_din,
    output logic [2:0]   din,
    output logic [Bit:0] len,
    output logic         done,
    output logic         err
);

    localparam logic [Bit:0] FULL_CNT = (Bit + 1)'(N);

    load_state_t  state, next_state;
    logic [Bit:0] count;
    logic [2:0]   code;
    logic         is_nt, is_term;
    logic         clear, wr_ok, fin_ok, fin_err;

    nt_encoder #(
        .G    (G),
        .C    (C),
        .A    (A),
        .T    (T),
        .TERM (TERM)
    ) u_enc (
        .char_in (char_in),
        .code    (code),
        .is_nt   (is_nt),
        .is_term (is_term)
    );

    assign char_ready = (state == ST_LOAD);
    assign we         = en_din;

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        wr_ok      = 1'b0;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;
        case (state)
            ST_LOAD: begin
                if (char_valid) begin
                    if (is_term) begin
                        fin_ok     = 1'b1;
                        next_state = ST_DONE;
                    end else if (is_nt && count != FULL_CNT) begin
                        wr_ok = 1'b1;
                    end else begin
                        // Bad character or RAM already full: abort without writing.
                        fin_err    = 1'b1;
                        next_state = ST_ERR;
                    end
                end
            end
            default: begin
                if (start) begin
                    clear      = 1'b1;
                    next_state = ST_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            len      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            en_din   <= 1'b0;
            addr_din <= '0;
            din      <= '0;
        end else begin
            en_din <= 1'b0;
            if (clear) begin
                count <= '0;
                len   <= '0;
                done  <= 1'b0;
                err   <= 1'b0;
            end
            if (wr_ok) begin
                en_din   <= 1'b1;
                addr_din <= count;
                din      <= code;
                count    <= count + 1'b1;
            end
            if (fin_ok) begin
                len  <= count;
                done <= 1'b1;
            end
            if (fin_err) begin
                len <= count;
                err <= 1'b1;
            end
        end
    end

endmodule
